// File: rtl/wb_conbus_rr_if.sv
// rtl/wb_conbus_rr_if.sv - Bus bundle for the round-robin Wishbone shared-bus interconnect
//
// Purpose: groups every master-side and slave-side Wishbone signal of
// wb_conbus_rr. Per-master and per-slave vectors are packed, index 0 in the LSBs.
// Modports:
//   conbus - the interconnect itself
//   master - the bus masters (drive m_*_i, observe m_*_o and gnt_o)
//   slave  - the peripheral slaves (observe s_*_o, drive s_dat_i/s_ack_i)
// Signals:
//   m_adr_i/m_dat_i/m_sel_i/m_we_i/m_cyc_i/m_stb_i  master requests
//   m_dat_o/m_ack_o/m_err_o                          master responses
//   s_adr_o/s_dat_o/s_sel_o/s_we_o                   broadcast to slaves
//   s_cyc_o/s_stb_o                                  selected-slave strobes
//   s_dat_i/s_ack_i                                  slave responses
//   gnt_o                                            one-hot grant (trace)
interface wb_conbus_rr_if #(
  parameter int NM = 2,
  parameter int NS = 6
);
  logic [NM*32-1:0] m_adr_i;
  logic [NM*32-1:0] m_dat_i;
  logic [NM*32-1:0] m_dat_o;
  logic [NM*4-1:0]  m_sel_i;
  logic [NM-1:0]    m_we_i;
  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [31:0]      s_adr_o;
  logic [31:0]      s_dat_o;
  logic [3:0]       s_sel_o;
  logic             s_we_o;
  logic [NS*32-1:0] s_dat_i;
  logic [NS-1:0]    s_cyc_o;
  logic [NS-1:0]    s_stb_o;
  logic [NS-1:0]    s_ack_i;
  logic [NM-1:0]    gnt_o;

  modport conbus (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    input  s_dat_i, s_ack_i,
    output gnt_o
  );

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
    input  m_dat_o, m_ack_o, m_err_o, gnt_o
  );

  modport slave (
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/wb_conbus_rr.sv
// rtl/wb_conbus_rr.sv - Round-robin Wishbone shared-bus interconnect, NM masters x NS slaves
//
// Purpose: one master at a time owns the shared bus. The grant is taken by a
// cyclic search starting after the last granted master and is held for the whole
// Wishbone cycle (cyc). The top S_ADDR_W address bits pick the slave; a miss
// terminates the access with m_err_o.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - wb_conbus_rr_if.conbus (all master/slave bus signals and gnt_o)
// Optional feature: define WB_CONBUS_TIMEOUT_EN to add a per-access timeout
// counter that ends a stalled access with m_err_o after TIMEOUT cycles.
module wb_conbus_rr #(
  parameter int NM = 2,
  parameter int NS = 6,
  parameter int S_ADDR_W = 3,
  parameter logic [NS*S_ADDR_W-1:0] S_ADDR = {3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b000},
  parameter int TIMEOUT = 255
) (
  input logic            clk,
  input logic            rst,
  wb_conbus_rr_if.conbus bus
);

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   last, last_nx;
  logic [IW-1:0]   arb_idx;
  logic            arb_found;
  int              arb_j;

  logic            busy;
  logic            g_cyc, g_stb, g_we;
  logic [31:0]     g_adr, g_dat;
  logic [3:0]      g_sel;

  logic [S_ADDR_W-1:0] tag;
  logic            hit;
  logic [SW-1:0]   sel_idx;

  logic            ack_rt;
  logic            err_rt;
  logic [31:0]     dat_rt;
  logic            miss_err;
  logic            to_kill;
  logic            to_err;

  // Cyclic search: first requester strictly after 'last', wrapping to 'last' itself.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = last;
    arb_j     = 0;
    for (int i = 1; i <= NM; i++) begin
      arb_j = (int'(last) + i) % NM;
      if (!arb_found && bus.m_cyc_i[arb_j]) begin
        arb_found = 1'b1;
        arb_idx   = IW'(arb_j);
      end
    end
  end

  // 'last' doubles as the index of the currently granted master while BUSY.
  always_comb begin
    state_nx = state;
    last_nx  = last;
    case (state)
      IDLE: begin
        if (arb_found) begin
          state_nx = BUSY;
          last_nx  = arb_idx;
        end
      end
      BUSY: begin
        if (!bus.m_cyc_i[last]) begin
          if (arb_found) begin
            last_nx = arb_idx;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last     <= IW'(NM - 1);
      miss_err <= 1'b0;
    end else begin
      state    <= state_nx;
      last     <= last_nx;
      // One pulse per strobe on a decode miss; the flag clears itself next cycle.
      miss_err <= g_stb && !hit && !miss_err;
    end
  end

  // Granted master's request, zero when nobody owns the bus.
  always_comb begin
    busy  = (state == BUSY);
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_we  = 1'b0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    if (busy) begin
      g_adr = bus.m_adr_i[int'(last)*32 +: 32];
      g_dat = bus.m_dat_i[int'(last)*32 +: 32];
      g_sel = bus.m_sel_i[int'(last)*4 +: 4];
      g_we  = bus.m_we_i[last];
      g_cyc = bus.m_cyc_i[last];
      g_stb = bus.m_cyc_i[last] && bus.m_stb_i[last];
    end
  end

  // Address decode; scanning downwards lets the lowest matching slave win.
  always_comb begin
    tag     = g_adr[31 -: S_ADDR_W];
    hit     = 1'b0;
    sel_idx = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      if (tag == S_ADDR[k*S_ADDR_W +: S_ADDR_W]) begin
        hit     = 1'b1;
        sel_idx = SW'(k);
      end
    end
  end

  // Ack is qualified by the live cyc/stb so a late ack after an abort is dropped.
  assign ack_rt = hit && g_stb && bus.s_ack_i[sel_idx];
  assign dat_rt = hit ? bus.s_dat_i[int'(sel_idx)*32 +: 32] : 32'h0;
  assign err_rt = g_cyc && (miss_err || to_err);

`ifdef WB_CONBUS_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);
  logic [15:0] to_cnt;

  // The kill does not look at ack, keeping s_stb_o free of any path from s_ack_i;
  // an ack in the same cycle still wins because the error is masked by it.
  assign to_kill = g_stb && (to_cnt == TO_LIM);
  assign to_err  = to_kill && !ack_rt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (!g_stb || ack_rt || err_rt) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 16'd1;
    end
  end
`else
  // TIMEOUT only matters when the counter is built in.
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT);
  assign to_kill = 1'b0;
  assign to_err  = 1'b0;
`endif

  always_comb begin
    bus.s_adr_o = g_adr;
    bus.s_dat_o = g_dat;
    bus.s_sel_o = g_sel;
    bus.s_we_o  = g_we;
    bus.s_cyc_o = '0;
    bus.s_stb_o = '0;
    if (hit && !to_kill) begin
      bus.s_cyc_o[sel_idx] = g_cyc;
      bus.s_stb_o[sel_idx] = g_stb;
    end
    bus.gnt_o   = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_dat_o = '0;
    if (busy) begin
      bus.gnt_o[last]                   = 1'b1;
      bus.m_ack_o[last]                 = ack_rt;
      bus.m_err_o[last]                 = err_rt;
      bus.m_dat_o[int'(last)*32 +: 32]  = dat_rt;
    end
  end

endmodule

// File: tb/tb_wb_conbus_rr.sv
// tb/tb_wb_conbus_rr.sv - Directed self-checking bench for wb_conbus_rr
module tb_wb_conbus_rr;

  localparam int NM = 2;
  localparam int NS = 6;
  localparam logic [17:0] SADDR = {3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b000};

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  wb_conbus_rr_if #(.NM(NM), .NS(NS)) bif ();

  wb_conbus_rr #(
    .NM(NM), .NS(NS), .S_ADDR_W(3), .S_ADDR(SADDR), .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int i, input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    bif.m_cyc_i[i]         = c;
    bif.m_stb_i[i]         = s;
    bif.m_we_i[i]          = w;
    bif.m_adr_i[i*32 +: 32] = a;
    bif.m_dat_i[i*32 +: 32] = d;
    bif.m_sel_i[i*4 +: 4]   = 4'hF;
  endtask

  logic [31:0] cont_adr [2];
  logic [5:0]  cont_sbit [2];

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bif.m_adr_i = '0;
    bif.m_dat_i = '0;
    bif.m_sel_i = '0;
    bif.m_we_i  = '0;
    bif.m_cyc_i = '0;
    bif.m_stb_i = '0;
    bif.s_ack_i = '0;
    bif.s_dat_i = {32'h5000_0005, 32'h5000_0004, 32'h5000_0003,
                   32'h5000_0002, 32'h5000_0001, 32'hDEAD_BEEF};
    cont_adr[0]  = 32'h0000_0020;
    cont_adr[1]  = 32'h4000_0004;
    cont_sbit[0] = 6'b000001;
    cont_sbit[1] = 6'b000010;

    // Reset state
    tick();
    tick();
    chk("rst_gnt",  bif.gnt_o,   0);
    chk("rst_scyc", bif.s_cyc_o, 0);
    chk("rst_sstb", bif.s_stb_o, 0);
    chk("rst_ack",  bif.m_ack_o, 0);
    chk("rst_err",  bif.m_err_o, 0);
    chk("rst_mdat", bif.m_dat_o, 0);
    rst = 1'b1;
    tick();
    chk("idle_gnt", bif.gnt_o, 0);

    // Contention: both masters request on the same edge, 4 transfers each
    set_m(0, 1, 1, 0, cont_adr[0], 32'h0);
    set_m(1, 1, 1, 1, cont_adr[1], 32'hCAFE_0001);
    tick();
    for (int n = 0; n < 8; n++) begin
      int g;
      g = n % 2;
      chk($sformatf("cont%0d_gnt", n), bif.gnt_o, 64'(2'b01 << g));
      chk($sformatf("cont%0d_scyc", n), bif.s_cyc_o, cont_sbit[g]);
      chk($sformatf("cont%0d_sadr", n), bif.s_adr_o, cont_adr[g]);
      if (g == 1) begin
        chk($sformatf("cont%0d_sdat", n), bif.s_dat_o, 32'hCAFE_0001);
        chk($sformatf("cont%0d_swe", n), bif.s_we_o, 1'b1);
      end
      bif.s_ack_i = cont_sbit[g];
      #1;
      chk($sformatf("cont%0d_ack", n), bif.m_ack_o, 64'(2'b01 << g));
      tick();
      bif.s_ack_i = '0;
      set_m(g, 0, 0, 0, cont_adr[g], 32'h0);
      #1;
      chk($sformatf("cont%0d_drop_scyc", n), bif.s_cyc_o, 0);
      tick();
      if (n < 6) set_m(g, 1, 1, g == 1, cont_adr[g], 32'hCAFE_0001);
    end
    chk("cont_idle_gnt", bif.gnt_o, 0);

    // Single-master read from bram
    set_m(0, 1, 1, 0, 32'h0000_0010, 32'h0);
    #1;
    chk("rd_pre_gnt", bif.gnt_o, 0);
    tick();
    chk("rd_gnt",  bif.gnt_o,   2'b01);
    chk("rd_scyc", bif.s_cyc_o, 6'b000001);
    chk("rd_sstb", bif.s_stb_o, 6'b000001);
    chk("rd_sadr", bif.s_adr_o, 32'h0000_0010);
    chk("rd_ack0", bif.m_ack_o, 0);
    tick();
    chk("rd_ack1", bif.m_ack_o, 0);
    bif.s_ack_i[0] = 1'b1;
    #1;
    chk("rd_ack", bif.m_ack_o, 2'b01);
    chk("rd_dat", bif.m_dat_o, 64'h0000_0000_DEAD_BEEF);
    tick();
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    bif.s_ack_i[0] = 1'b0;
    #1;
    chk("rd_drop_scyc", bif.s_cyc_o, 0);
    tick();
    chk("rd_idle_gnt", bif.gnt_o, 0);

    // Decode miss from master 1
    set_m(1, 1, 1, 0, 32'hE000_0000, 32'h0);
    tick();
    chk("miss_gnt",  bif.gnt_o,   2'b10);
    chk("miss_scyc", bif.s_cyc_o, 0);
    chk("miss_err0", bif.m_err_o, 0);
    tick();
    chk("miss_err",   bif.m_err_o, 2'b10);
    chk("miss_ack",   bif.m_ack_o, 0);
    chk("miss_scyc1", bif.s_cyc_o, 0);
    tick();
    chk("miss_err_once", bif.m_err_o, 0);
    set_m(1, 0, 0, 0, 32'h0, 32'h0);
    tick();
    chk("miss_idle_gnt", bif.gnt_o, 0);

    // Uart never acks
    set_m(0, 1, 1, 0, 32'hC000_0000, 32'h0);
    tick();
    chk("to_gnt",  bif.gnt_o,   2'b01);
    chk("to_sstb0", bif.s_stb_o, 6'b100000);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("to_wait%0d_err", i), bif.m_err_o, 0);
    end
    tick();
`ifdef WB_CONBUS_TIMEOUT_EN
    chk("to_err",  bif.m_err_o, 2'b01);
    chk("to_sstb", bif.s_stb_o, 0);
    chk("to_scyc", bif.s_cyc_o, 0);
`else
    chk("to_noerr", bif.m_err_o, 0);
    chk("to_sstb",  bif.s_stb_o, 6'b100000);
`endif
    tick();
    chk("to_after_err",  bif.m_err_o, 0);
    chk("to_after_sstb", bif.s_stb_o, 6'b100000);
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    chk("to_idle_gnt", bif.gnt_o, 0);

    // Asynchronous reset while master 0 talks to gpio
    set_m(0, 1, 1, 1, 32'h4000_0000, 32'h1234_5678);
    tick();
    chk("rr_gnt",  bif.gnt_o,   2'b01);
    chk("rr_scyc", bif.s_cyc_o, 6'b000010);
    #2;
    rst = 1'b0;
    bif.s_ack_i[1] = 1'b1;
    #1;
    chk("rr_gnt0",  bif.gnt_o,   0);
    chk("rr_scyc0", bif.s_cyc_o, 0);
    chk("rr_sstb0", bif.s_stb_o, 0);
    chk("rr_ack0",  bif.m_ack_o, 0);
    chk("rr_err0",  bif.m_err_o, 0);
    chk("rr_mdat0", bif.m_dat_o, 0);
    set_m(1, 1, 1, 0, 32'h4000_0000, 32'h0);
    tick();
    chk("rr_hold_gnt", bif.gnt_o, 0);
    rst = 1'b1;
    bif.s_ack_i[1] = 1'b0;
    tick();
    chk("rr_first_gnt", bif.gnt_o, 2'b01);
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    set_m(1, 0, 0, 0, 32'h0, 32'h0);
    tick();
    chk("rr_idle_gnt", bif.gnt_o, 0);

    // Master 0 aborts with master 1 pending
    set_m(0, 1, 1, 0, 32'h0000_0100, 32'h0);
    tick();
    chk("ab_gnt",  bif.gnt_o,   2'b01);
    chk("ab_scyc", bif.s_cyc_o, 6'b000001);
    set_m(1, 1, 1, 0, 32'h4000_0008, 32'h0);
    set_m(0, 0, 0, 0, 32'h0000_0100, 32'h0);
    bif.s_ack_i[0] = 1'b1;
    #1;
    chk("ab_drop_scyc", bif.s_cyc_o, 0);
    chk("ab_late_ack",  bif.m_ack_o, 0);
    tick();
    chk("ab_gnt2",  bif.gnt_o,   2'b10);
    chk("ab_scyc2", bif.s_cyc_o, 6'b000010);
    chk("ab_ack2",  bif.m_ack_o, 0);
    bif.s_ack_i[0] = 1'b0;
    bif.s_ack_i[1] = 1'b1;
    #1;
    chk("ab_ack3", bif.m_ack_o, 2'b10);
    chk("ab_dat3", bif.m_dat_o, 64'h5000_0001_0000_0000);
    tick();
    set_m(1, 0, 0, 0, 32'h0, 32'h0);
    bif.s_ack_i[1] = 1'b0;
    tick();
    chk("ab_idle_gnt", bif.gnt_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
